// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the control-flow class codes and the FSM state encoding.
package pc_sequencer_pkg;

  localparam int unsigned ARG_WIDTH_DEF   = 8;
  localparam int unsigned STACK_DEPTH_DEF = 8;
  localparam int unsigned CF_W            = 3;

  typedef enum logic [CF_W-1:0] {
    CF_NONE = 3'd0,
    CF_JMP  = 3'd1,
    CF_JZ   = 3'd2,
    CF_JNZ  = 3'd3,
    CF_CALL = 3'd4,
    CF_RET  = 3'd5,
    CF_HALT = 3'd6
  } cf_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/PC-facing bundle of the sequencer: op inputs in, PC load and status out.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned ARG_WIDTH   = ARG_WIDTH_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
);
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH) + 1;

  logic                 op_valid;
  logic [CF_W-1:0]      op_class;
  logic [ARG_WIDTH-1:0] op_arg;
  logic [ARG_WIDTH-1:0] pc_cur;
  logic                 zero_flag;
  logic                 resume;
  logic                 pc_set;
  logic [ARG_WIDTH-1:0] pc_set_addr;
  logic                 halted;
  logic                 fault;
  logic [DEPTH_W-1:0]   sp_depth;

  modport master (
    output op_valid, op_class, op_arg, pc_cur, zero_flag, resume,
    input  pc_set, pc_set_addr, halted, fault, sp_depth
  );

  modport slave (
    input  op_valid, op_class, op_arg, pc_cur, zero_flag, resume,
    output pc_set, pc_set_addr, halted, fault, sp_depth
  );
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO: registered storage and pointers, combinational top-of-stack.
module pc_sequencer_ret_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign depth = cnt_q;
  // ptr_q is the next free slot; wraps modulo DEPTH since DEPTH is a power of two.
  assign top   = mem_q[ptr_q - PTR_W'(1)];

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push && !full) begin
      ptr_d = ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entries are left unreset; the depth count alone defines validity.
  always_ff @(posedge CLK) begin
    if (RST_N && push && !full) mem_q[ptr_q] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Control-flow controller: drives the PC load port for jumps, call/return,
// halt and reset vectoring, with a RUN/HALT/FAULT state machine.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned          ARG_WIDTH   = ARG_WIDTH_DEF,
  parameter int unsigned          STACK_DEPTH = STACK_DEPTH_DEF,
  parameter logic [ARG_WIDTH-1:0] RESET_VEC   = '0
) (
  input  logic           CLK,
  input  logic           RST_N,
  pc_sequencer_if.slave  bus
);
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH) + 1;

  state_e               state_q, state_d;
  logic                 halted_q, fault_q;
  logic                 push, pop;
  logic                 stk_full, stk_empty;
  logic [ARG_WIDTH-1:0] stk_top;
  logic [DEPTH_W-1:0]   stk_depth;
  logic [ARG_WIDTH-1:0] ret_addr;

  assign ret_addr     = bus.pc_cur + ARG_WIDTH'(1);
  assign bus.halted   = halted_q;
  assign bus.fault    = fault_q;
  assign bus.sp_depth = stk_depth;

  pc_sequencer_ret_stack #(
    .WIDTH (ARG_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr),
    .top   (stk_top),
    .depth (stk_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == ST_HALT);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  // Next state and PC load; holding the PC means loading pc_cur.
  always_comb begin
    state_d         = state_q;
    bus.pc_set      = 1'b0;
    bus.pc_set_addr = bus.pc_cur;
    push            = 1'b0;
    pop             = 1'b0;
    if (!RST_N) begin
      bus.pc_set      = 1'b1;
      bus.pc_set_addr = RESET_VEC;
      state_d         = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.op_valid) begin
            case (cf_e'(bus.op_class))
              CF_JMP: begin
                bus.pc_set      = 1'b1;
                bus.pc_set_addr = bus.op_arg;
              end
              CF_JZ, CF_JNZ: begin
                if (bus.zero_flag == (cf_e'(bus.op_class) == CF_JZ)) begin
                  bus.pc_set      = 1'b1;
                  bus.pc_set_addr = bus.op_arg;
                end
              end
              CF_CALL: begin
                bus.pc_set = 1'b1;
                if (!stk_full) begin
                  push            = 1'b1;
                  bus.pc_set_addr = bus.op_arg;
                end else begin
                  state_d = ST_FAULT;
                end
              end
              CF_RET: begin
                bus.pc_set = 1'b1;
                if (!stk_empty) begin
                  pop             = 1'b1;
                  bus.pc_set_addr = stk_top;
                end else begin
                  state_d = ST_FAULT;
                end
              end
              CF_HALT: begin
                bus.pc_set = 1'b1;
                state_d    = ST_HALT;
              end
              default: ;
            endcase
          end
        end
        ST_HALT: begin
          if (bus.resume) state_d = ST_RUN;
          else            bus.pc_set = 1'b1;
        end
        ST_FAULT: bus.pc_set = 1'b1;
        default: begin
          bus.pc_set = 1'b1;
          state_d    = ST_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC register closing the loop.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned SD = 8;

  logic          CLK;
  logic          RST_N;
  logic [AW-1:0] pc;
  int            vectors;
  int            miscompares;

  pc_sequencer_if #(.ARG_WIDTH(AW), .STACK_DEPTH(SD)) bus ();

  pc_sequencer #(
    .ARG_WIDTH   (AW),
    .STACK_DEPTH (SD),
    .RESET_VEC   (8'h10)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Program counter: loads on pc_set, otherwise increments.
  always @(posedge CLK) pc <= bus.pc_set ? bus.pc_set_addr : pc + 8'd1;
  assign bus.pc_cur = pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one op away from the rising edge and let combinational outputs settle.
  task automatic step(input logic rst_n, input logic v, input logic [2:0] cls,
                      input logic [7:0] arg, input logic zf, input logic res);
    @(negedge CLK);
    RST_N         = rst_n;
    bus.op_valid  = v;
    bus.op_class  = cls;
    bus.op_arg    = arg;
    bus.zero_flag = zf;
    bus.resume    = res;
    #1;
  endtask

  task automatic chk_set(input string tag, input logic set, input logic [7:0] addr);
    chk({tag, "_set"}, 32'(bus.pc_set), 32'(set));
    if (set) chk({tag, "_addr"}, 32'(bus.pc_set_addr), 32'(addr));
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    RST_N         = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op_class  = 3'd0;
    bus.op_arg    = 8'h00;
    bus.zero_flag = 1'b0;
    bus.resume    = 1'b0;

    // Reset vectoring.
    step(1'b0, 1'b0, CF_NONE, 8'h00, 1'b0, 1'b0); chk_set("rst0", 1'b1, 8'h10);
    step(1'b0, 1'b0, CF_NONE, 8'h00, 1'b0, 1'b0); chk_set("rst1", 1'b1, 8'h10);
    step(1'b1, 1'b1, CF_NONE, 8'h00, 1'b0, 1'b0); chk_set("none0", 1'b0, 8'h00);
    chk("pc_rst", 32'(pc), 32'h10);
    chk("halted_rst", 32'(bus.halted), 32'h0);
    chk("fault_rst", 32'(bus.fault), 32'h0);
    chk("depth_rst", 32'(bus.sp_depth), 32'h0);
    step(1'b1, 1'b1, CF_NONE, 8'h00, 1'b0, 1'b0); chk_set("none1", 1'b0, 8'h00);
    step(1'b1, 1'b1, CF_NONE, 8'h00, 1'b0, 1'b0); chk_set("none2", 1'b0, 8'h00);
    step(1'b1, 1'b1, 3'd7, 8'h55, 1'b1, 1'b0);     chk_set("undef", 1'b0, 8'h00);
    chk("pc_13", 32'(pc), 32'h13);
    step(1'b1, 1'b0, CF_JMP, 8'h44, 1'b0, 1'b0);   chk_set("novalid", 1'b0, 8'h00);

    // Conditional jumps.
    step(1'b1, 1'b1, CF_JZ, 8'h05, 1'b0, 1'b0);  chk_set("jz_nt", 1'b0, 8'h00);
    step(1'b1, 1'b1, CF_JZ, 8'h05, 1'b1, 1'b0);  chk_set("jz_t", 1'b1, 8'h05);
    step(1'b1, 1'b1, CF_JNZ, 8'h05, 1'b1, 1'b0); chk_set("jnz_nt", 1'b0, 8'h00);
    chk("pc_jz", 32'(pc), 32'h05);
    step(1'b1, 1'b1, CF_JNZ, 8'h05, 1'b0, 1'b0); chk_set("jnz_t", 1'b1, 8'h05);
    step(1'b1, 1'b1, CF_JMP, 8'h03, 1'b0, 1'b0); chk_set("jmp", 1'b1, 8'h03);

    // Nested call / return.
    step(1'b1, 1'b1, CF_CALL, 8'h20, 1'b0, 1'b0); chk_set("call1", 1'b1, 8'h20);
    chk("pc_call1", 32'(pc), 32'h03);
    step(1'b1, 1'b1, CF_NONE, 8'h00, 1'b0, 1'b0);
    chk("depth1", 32'(bus.sp_depth), 32'd1);
    step(1'b1, 1'b1, CF_CALL, 8'h30, 1'b0, 1'b0); chk_set("call2", 1'b1, 8'h30);
    chk("pc_call2", 32'(pc), 32'h21);
    step(1'b1, 1'b1, CF_RET, 8'h00, 1'b0, 1'b0);  chk_set("ret1", 1'b1, 8'h22);
    chk("depth2", 32'(bus.sp_depth), 32'd2);
    chk("pc_30", 32'(pc), 32'h30);
    step(1'b1, 1'b1, CF_RET, 8'h00, 1'b0, 1'b0);  chk_set("ret2", 1'b1, 8'h04);
    chk("depth3", 32'(bus.sp_depth), 32'd1);
    step(1'b1, 1'b1, CF_NONE, 8'h00, 1'b0, 1'b0);
    chk("depth4", 32'(bus.sp_depth), 32'd0);
    chk("pc_04", 32'(pc), 32'h04);

    // Return-address wrap at the top of the address space.
    step(1'b1, 1'b1, CF_JMP, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 1'b1, CF_CALL, 8'h60, 1'b0, 1'b0); chk_set("call_wrap", 1'b1, 8'h60);
    step(1'b1, 1'b1, CF_RET, 8'h00, 1'b0, 1'b0);  chk_set("ret_wrap", 1'b1, 8'h00);

    // Underflow fault.
    step(1'b1, 1'b1, CF_JMP, 8'h07, 1'b0, 1'b0);
    step(1'b1, 1'b1, CF_RET, 8'h00, 1'b0, 1'b0);  chk_set("uflow", 1'b1, 8'h07);
    chk("pc_07", 32'(pc), 32'h07);
    step(1'b1, 1'b1, CF_JMP, 8'h10, 1'b0, 1'b0);  chk_set("fault_jmp", 1'b1, 8'h07);
    chk("fault_uflow", 32'(bus.fault), 32'h1);
    step(1'b1, 1'b0, CF_NONE, 8'h00, 1'b0, 1'b1); chk_set("fault_res", 1'b1, 8'h07);
    step(1'b1, 1'b0, CF_NONE, 8'h00, 1'b0, 1'b0);
    chk("fault_sticky", 32'(bus.fault), 32'h1);
    step(1'b0, 1'b0, CF_NONE, 8'h00, 1'b0, 1'b0); chk_set("rst2", 1'b1, 8'h10);

    // Overflow: eight pushes fill the stack, the ninth call faults.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, CF_CALL, 8'(8'h40 + i), 1'b0, 1'b0);
      if (i == 0) chk("fault_cleared", 32'(bus.fault), 32'h0);
      chk_set("call_fill", 1'b1, 8'(8'h40 + i));
      chk("depth_fill", 32'(bus.sp_depth), 32'(i));
    end
    step(1'b1, 1'b1, CF_CALL, 8'h50, 1'b0, 1'b0); chk_set("oflow", 1'b1, 8'h47);
    chk("depth_full", 32'(bus.sp_depth), 32'd8);
    step(1'b1, 1'b1, CF_RET, 8'h00, 1'b0, 1'b1);  chk_set("oflow_hold", 1'b1, 8'h47);
    chk("fault_oflow", 32'(bus.fault), 32'h1);
    chk("depth_oflow", 32'(bus.sp_depth), 32'd8);
    step(1'b0, 1'b0, CF_NONE, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, CF_RET, 8'h00, 1'b0, 1'b0);  chk_set("ret_after_rst", 1'b1, 8'h10);
    chk("depth_clr", 32'(bus.sp_depth), 32'd0);
    chk("fault_clr", 32'(bus.fault), 32'h0);
    step(1'b0, 1'b0, CF_NONE, 8'h00, 1'b0, 1'b0);

    // Halt and resume.
    step(1'b1, 1'b1, CF_JMP, 8'h0A, 1'b0, 1'b0);
    step(1'b1, 1'b1, CF_HALT, 8'h00, 1'b0, 1'b0); chk_set("halt", 1'b1, 8'h0A);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, CF_JMP, 8'h33, 1'b0, 1'b0);
      chk_set("halt_hold", 1'b1, 8'h0A);
      chk("halted", 32'(bus.halted), 32'h1);
    end
    step(1'b1, 1'b0, CF_NONE, 8'h00, 1'b0, 1'b1); chk_set("resume", 1'b0, 8'h00);
    step(1'b1, 1'b1, CF_NONE, 8'h00, 1'b0, 1'b0); chk_set("run_again", 1'b0, 8'h00);
    chk("halted_clr", 32'(bus.halted), 32'h0);
    chk("pc_0b", 32'(pc), 32'h0B);
    chk("fault_halt", 32'(bus.fault), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
